// File: rtl/svi_stream_pkg.sv
// svi_stream_pkg: shared types and helpers for the valid/ready byte stream.
//   DATA_W    : payload width of one stream word
//   data_t    : payload type carried on the S interface
//   even_par  : XOR-reduction of a payload word; a word is valid when
//               even_par(data) ^ par == 0
package svi_stream_pkg;

    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    function automatic logic even_par(data_t d);
        return ^d;
    endfunction

endpackage

// File: rtl/svi_stream_if.sv
// S: valid/ready byte stream with an even-parity bit.
//   Tx modport : producer side (drives valid, data, par; reads ready)
//   Rx modport : consumer side (reads valid, data, par; drives ready)
interface S;
    import svi_stream_pkg::*;

    data_t data;
    logic  valid;
    logic  ready;
    logic  par;

    modport Tx (output valid, output data, output par, input ready);
    modport Rx (input valid, input data, input par, output ready);

endinterface

// File: rtl/svi_stream_fifo.sv
// svi_stream_fifo: DEPTH-entry register FIFO with naturally wrapping pointers.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write wdata at the tail (caller guarantees !full)
//   pop        : drop the head word (caller guarantees !empty)
//   rdata      : head word, combinational from state
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module svi_stream_fifo
    import svi_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  data_t                  wdata,
    output data_t                  rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset: contents are only observable while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/svi_stream_rx.sv
// svi_stream_rx: receiving end of the S stream. Accepted words with good even
// parity are buffered in a FIFO and presented downstream; words with bad
// parity complete the handshake but are dropped and counted.
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   s               : S.Rx upstream port (valid/data/par in, ready out)
//   o_data/o_valid  : head-of-FIFO word and non-empty flag
//   i_ready         : downstream takes o_data this cycle
//   o_count         : FIFO occupancy
//   o_err_cnt       : saturating count of dropped parity-failing words
module svi_stream_rx
    import svi_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    S.Rx                           s,
    output data_t                  o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [ERR_W-1:0]       o_err_cnt
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             ready_q;
    logic             push_attempt;
    logic             par_ok;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [ERR_W-1:0] err_cnt;

    assign push_attempt = s.valid & ready_q;
    assign par_ok       = ~(even_par(s.data) ^ s.par);
    // ready_q already excludes the full case; the full term only guards the FIFO.
    assign push         = push_attempt & par_ok & ~full;
    assign pop          = ~empty & i_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            ready_q <= 1'b0;
            err_cnt <= '0;
        end else begin
            ready_q <= (count_next != CW'(DEPTH));
            if (push_attempt && !par_ok && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    svi_stream_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_arst_n),
        .push  (push),
        .pop   (pop),
        .wdata (s.data),
        .rdata (o_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign s.ready   = ready_q;
    assign o_valid   = ~empty;
    assign o_count   = count;
    assign o_err_cnt = err_cnt;

endmodule

// File: tb/tb_svi_stream_rx.sv
// tb_svi_stream_rx: directed and randomized stimulus for svi_stream_rx,
// checked each cycle against a queue-based reference of the stream rules.
module tb_svi_stream_rx;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rdy;
    logic [7:0] o_data;
    logic       o_valid;
    logic [2:0] o_count;
    logic [7:0] o_err_cnt;

    logic [7:0] d2;
    logic       v2;
    logic [2:0] c2;
    logic [1:0] e2;

    S sif ();
    S sif2 ();

    svi_stream_rx #(.DEPTH(DEPTH), .ERR_W(8)) dut (
        .i_clk     (clk),
        .i_arst_n  (rst_n),
        .s         (sif),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (rdy),
        .o_count   (o_count),
        .o_err_cnt (o_err_cnt)
    );

    svi_stream_rx #(.DEPTH(DEPTH), .ERR_W(2)) dut_sat (
        .i_clk     (clk),
        .i_arst_n  (rst_n),
        .s         (sif2),
        .o_data    (d2),
        .o_valid   (v2),
        .i_ready   (1'b0),
        .o_count   (c2),
        .o_err_cnt (e2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [7:0] q[$];
    int         m_err = 0;
    bit         m_ready = 1'b0;
    bit         last_acc = 1'b0;
    bit         chk_le1 = 1'b0;

    // current drive
    bit         cur_v = 1'b0;
    logic [7:0] cur_d = 8'h00;
    bit         cur_p = 1'b0;
    bit         cur_r = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("s_ready", {31'd0, sif.ready}, {31'd0, m_ready});
        chk("o_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
        chk("o_count", {29'd0, o_count}, q.size());
        chk("o_err_cnt", {24'd0, o_err_cnt}, m_err);
        if (q.size() != 0) chk("o_data", {24'd0, o_data}, {24'd0, q[0]});
        if (chk_le1) chk("stream_count_le1", {31'd0, o_count <= 3'd1}, 32'd1);
    endtask

    task automatic drive(bit v, logic [7:0] d, bit p, bit r);
        cur_v = v; cur_d = d; cur_p = p; cur_r = r;
        sif.valid = v; sif.data = d; sif.par = p; rdy = r;
    endtask

    // One rising edge: apply the stream rules to the reference, then compare.
    task automatic tick();
        bit acc, ok, popm;
        @(posedge clk);
        if (!rst_n) begin
            q.delete(); m_err = 0; m_ready = 1'b0; last_acc = 1'b0;
        end else begin
            acc  = cur_v && m_ready;
            ok   = ((^cur_d) ^ cur_p) == 1'b0;
            popm = (q.size() != 0) && cur_r;
            if (popm) void'(q.pop_front());
            if (acc && ok) q.push_back(cur_d);
            else if (acc && m_err < 255) m_err++;
            m_ready  = (q.size() != DEPTH);
            last_acc = acc;
        end
        #1;
        check_all();
    endtask

    task automatic drain();
        int n = 0;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        while (q.size() != 0 && n < 20) begin tick(); n++; end
        chk("drain_empty", q.size(), 0);
    endtask

    // Offers nwords to the DUT; a word offered while not ready is held.
    task automatic run_stream(int nwords, int v_pct, int r_pct, int bad_pct, bit seq);
        int sent = 0;
        int cyc = 0;
        logic [7:0] d;
        bit p;
        while (sent < nwords && cyc < 3000) begin
            d = seq ? 8'(sent) : 8'($urandom);
            p = ^d;
            if ($urandom_range(99) < bad_pct) p = ~p;
            drive($urandom_range(99) < v_pct, d, p, $urandom_range(99) < r_pct);
            tick(); cyc++;
            while (cur_v && !last_acc && cyc < 3000) begin
                drive(cur_v, cur_d, cur_p, $urandom_range(99) < r_pct);
                tick(); cyc++;
            end
            if (cur_v && last_acc) sent++;
        end
        chk("stream_words_sent", sent, nwords);
    endtask

    initial begin
        logic [7:0] words [4];
        words[0] = 8'hA5; words[1] = 8'h01; words[2] = 8'hFF; words[3] = 8'h80;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        sif2.valid = 1'b0; sif2.data = 8'h00; sif2.par = 1'b0;

        // 1: reset held 3 cycles, ready rises one edge after release
        #1; check_all();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", {31'd0, sif.ready}, 32'd1);

        // 2: ordered fill (parity bits as given) then drain
        chk("par_table", {28'd0, ^words[0], ^words[1], ^words[2], ^words[3]}, 32'b0101);
        drive(1'b1, 8'hA5, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h01, 1'b1, 1'b0); tick();
        drive(1'b1, 8'hFF, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h80, 1'b1, 1'b0); tick();
        chk("fill_count4", {29'd0, o_count}, 32'd4);
        chk("fill_ready0", {31'd0, sif.ready}, 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", {24'd0, o_data}, {24'd0, words[i]});
            tick();
        end
        chk("drain_count0", {29'd0, o_count}, 32'd0);

        // 3: bad parity consumed and counted, good one stored
        drive(1'b1, 8'h03, 1'b1, 1'b0); tick();
        chk("bad_err1", {24'd0, o_err_cnt}, 32'd1);
        chk("bad_count0", {29'd0, o_count}, 32'd0);
        drive(1'b1, 8'h03, 1'b0, 1'b0); tick();
        chk("good_count1", {29'd0, o_count}, 32'd1);
        drain();

        // 4: full with simultaneous pop, then wrap-around stream
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h40 + i), ^(8'(8'h40 + i)), 1'b0); tick();
        end
        drive(1'b1, 8'h77, ^(8'h77), 1'b1); tick();
        chk("full_pop_count3", {29'd0, o_count}, 32'd3);
        chk("full_pop_ready1", {31'd0, sif.ready}, 32'd1);
        drive(1'b1, 8'h77, ^(8'h77), 1'b0); tick();
        run_stream(10, 100, 100, 0, 1'b0);
        drain();

        // 5: continuous streaming of 0..19
        chk_le1 = 1'b1;
        run_stream(20, 100, 100, 0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1); tick();
        chk_le1 = 1'b0;
        drain();

        // randomized traffic with occasional parity errors
        run_stream(150, 70, 60, 12, 1'b0);
        drain();

        // 6a: asynchronous reset with two words buffered
        drive(1'b1, 8'h11, ^(8'h11), 1'b0); tick();
        drive(1'b1, 8'h22, ^(8'h22), 1'b0); tick();
        chk("pre_reset_count2", {29'd0, o_count}, 32'd2);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #3; rst_n = 1'b0; #1;
        q.delete(); m_err = 0; m_ready = 1'b0; last_acc = 1'b0;
        check_all();
        tick();
        rst_n = 1'b1;
        tick();

        // 6b: saturation with ERR_W=2
        sif2.valid = 1'b1; sif2.data = 8'h01; sif2.par = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("sat_err", {30'd0, e2}, (k < 3) ? k : 3);
            chk("sat_count", {29'd0, c2}, 32'd0);
            chk("sat_ready", {31'd0, sif2.ready}, 32'd1);
        end
        sif2.valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
